// File: rtl/int_to_fpu_if.sv
// Shared float-format definitions and the start/done handshake bundle between an
// integer source and the int_to_fpu converter.
package int_to_fpu_pkg;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } status_t;
endpackage

interface int_to_fpu_if #(
    parameter int unsigned INT_W = 32
);
    import int_to_fpu_pkg::*;

    logic                start;
    logic [INT_W-1:0]    int_in;
    logic                busy;
    logic                done;
    logic [WORD_W-1:0]   data_out;
    status_t             status_out;

    modport master (
        output start, int_in,
        input  busy, done, data_out, status_out
    );

    modport slave (
        input  start, int_in,
        output busy, done, data_out, status_out
    );
endinterface

// File: rtl/int_to_fpu.sv
// Multi-cycle signed integer to packed float converter: takes the magnitude, normalizes
// one bit per clock, then packs sign/exponent/fraction with truncation.
module int_to_fpu
    import int_to_fpu_pkg::*;
#(
    parameter int unsigned INT_W  = 32,
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned FRAC_W = 21,
    parameter int unsigned BIAS   = 511
) (
    input  logic          clock_100Khz,
    input  logic          reset,
    int_to_fpu_if.slave   bus
);
    localparam int unsigned CNT_W    = $clog2(INT_W);
    localparam int unsigned STICKY_W = INT_W - 1 - FRAC_W;

    typedef enum logic [1:0] {IDLE, ABS, NORMALIZE, PACK} state_t;

    state_t             state;
    logic [INT_W-1:0]   op;
    logic [INT_W-1:0]   mag;
    logic               sign;
    logic [CNT_W-1:0]   cnt;

    logic [EXP_W-1:0]   exp_c;
    logic [FRAC_W-1:0]  frac_c;
    logic               sticky_c;

    // Field extraction from the normalized magnitude; the leading 1 at mag[INT_W-1] is dropped.
    always_comb begin
        exp_c    = EXP_W'(BIAS + (INT_W - 1) - 32'(cnt));
        frac_c   = mag[INT_W-2 -: FRAC_W];
        sticky_c = |mag[STICKY_W-1:0];
    end

    always_ff @(posedge clock_100Khz) begin
        if (!reset) begin
            state          <= IDLE;
            op             <= '0;
            mag            <= '0;
            sign           <= 1'b0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.data_out   <= '0;
            bus.status_out <= EXACT;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op       <= bus.int_in;
                        bus.busy <= 1'b1;
                        state    <= ABS;
                    end
                end
                ABS: begin
                    // Unsigned magnitude makes the most negative input come out as 2^(INT_W-1).
                    sign  <= op[INT_W-1];
                    mag   <= op[INT_W-1] ? -op : op;
                    cnt   <= '0;
                    state <= (op == '0) ? PACK : NORMALIZE;
                end
                NORMALIZE: begin
                    if (!mag[INT_W-1]) begin
                        mag <= mag << 1;
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    if (mag == '0) begin
                        bus.data_out   <= '0;
                        bus.status_out <= EXACT;
                    end else begin
                        bus.data_out   <= {sign, exp_c, frac_c};
                        bus.status_out <= sticky_c ? INEXACT : EXACT;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_fpu.sv
// Directed-vector bench for int_to_fpu: checks packed results, status, handshake timing,
// reset mid-conversion, ignored starts while busy and back-to-back conversions.
module tb_int_to_fpu;
    import int_to_fpu_pkg::*;

    localparam int unsigned MAX_WAIT = 100;

    logic clock_100Khz = 1'b0;
    logic reset        = 1'b0;
    int   checks       = 0;
    int   failures     = 0;

    int_to_fpu_if #(.INT_W(32)) bus ();

    int_to_fpu dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .bus          (bus)
    );

    always #5 clock_100Khz = ~clock_100Khz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one conversion and waits for done; optionally pulses start with junk while busy.
    task automatic convert(input string tag, input logic [31:0] value,
                           input logic [31:0] exp_data, input status_t exp_status,
                           input int exp_lat, input bit noisy);
        int n;
        @(negedge clock_100Khz);
        bus.int_in = value;
        bus.start  = 1'b1;
        @(posedge clock_100Khz);
        #1;
        bus.start  = 1'b0;
        n = 0;
        while (n < int'(MAX_WAIT)) begin
            if (noisy && n < 20) begin
                bus.start  = 1'b1;
                bus.int_in = 32'hDEAD_BEEF ^ 32'(n);
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge clock_100Khz);
            #1;
            n++;
            if (n == 1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"}, bus.data_out, exp_data);
        check({tag, "_status"}, 32'(bus.status_out), 32'(exp_status));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        bus.start  = 1'b0;
        bus.int_in = '0;
        repeat (3) @(posedge clock_100Khz);
        #1;
        check("rst_data", bus.data_out, 32'h0);
        check("rst_status", 32'(bus.status_out), 32'(EXACT));
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clock_100Khz);
        reset = 1'b1;

        convert("one",     32'h0000_0001, 32'h3FE0_0000, EXACT,   34, 1'b0);
        convert("neg_one", 32'hFFFF_FFFF, 32'hBFE0_0000, EXACT,   34, 1'b0);
        convert("min_int", 32'h8000_0000, 32'hC3C0_0000, EXACT,    3, 1'b0);
        convert("max_int", 32'h7FFF_FFFF, 32'h43BF_FFFF, INEXACT,  4, 1'b0);
        convert("bit21",   32'h0020_0000, 32'h4280_0000, EXACT,   13, 1'b0);
        convert("zero",    32'h0000_0000, 32'h0000_0000, EXACT,    2, 1'b0);
        convert("three",   32'h0000_0003, 32'h4010_0000, EXACT,   33, 1'b0);
        convert("neg_five",32'hFFFF_FFFB, 32'hC028_0000, EXACT,   32, 1'b0);
        convert("mixed",   32'h1234_5678, 32'h4364_68AC, INEXACT,  6, 1'b0);
        convert("noisy",   32'h0000_0001, 32'h3FE0_0000, EXACT,   34, 1'b1);

        // Reset in the middle of NORMALIZE discards the conversion and clears outputs.
        @(negedge clock_100Khz);
        bus.int_in = 32'h0000_0001;
        bus.start  = 1'b1;
        @(negedge clock_100Khz);
        bus.start  = 1'b0;
        repeat (8) @(negedge clock_100Khz);
        reset = 1'b0;
        @(posedge clock_100Khz);
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_data", bus.data_out, 32'h0);
        check("midrst_status", 32'(bus.status_out), 32'(EXACT));
        @(negedge clock_100Khz);
        reset = 1'b1;
        repeat (40) @(posedge clock_100Khz);
        #1;
        check("midrst_no_done", 32'(bus.done), 32'd0);

        // Start held high: second operand is taken in the cycle done is high.
        @(negedge clock_100Khz);
        bus.int_in = 32'h8000_0000;
        bus.start  = 1'b1;
        @(posedge clock_100Khz);
        #1;
        bus.int_in = 32'h0000_0000;
        n = 0;
        while (n < int'(MAX_WAIT)) begin
            @(posedge clock_100Khz);
            #1;
            n++;
            if (bus.done) break;
        end
        check("b2b_first_lat", 32'(n), 32'd3);
        check("b2b_first_data", bus.data_out, 32'hC3C0_0000);
        @(posedge clock_100Khz);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (n < int'(MAX_WAIT)) begin
            @(posedge clock_100Khz);
            #1;
            n++;
            if (bus.done) break;
        end
        check("b2b_second_lat", 32'(n), 32'd2);
        check("b2b_second_data", bus.data_out, 32'h0);
        check("b2b_second_status", 32'(bus.status_out), 32'(EXACT));

        repeat (2) @(posedge clock_100Khz);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
